cache_tag_ctrl: RTL

//   Controller for one port of the 2048x9 cache tag RAM. Per entry: bit8 = valid, bits7:0 = tag.
//   - Clears all tags after reset and on request.
//   - Services lookups from the CPU-side cache logic: read tag, compare, report hit/miss.
//   - On a miss, handshakes a line fill with the memory side, then writes the new tag.
//   - Sits between the cache data path and tag RAM port A; port B is left to the snooper.

---
 rtl/cache_tag_ctrl_if.sv | 33 +++
 rtl/cache_tag_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cache_tag_ctrl_if.sv
// Bundle of CPU lookup, memory fill and tag RAM port-A signals around cache_tag_ctrl.
// The controller uses the slave modport; its surroundings use master.
interface cache_tag_ctrl_if #(
  parameter int unsigned ADDR_W = 24
);
  // CPU-side lookup
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_hit;
  logic              inv_all;
  // Memory-side line fill
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_ack;
  logic              fill_done;
  // Tag RAM port A
  logic [10:0]       tag_addr;
  logic [8:0]        tag_wrdata;
  logic              tag_wren;
  logic [8:0]        tag_rddata;

  modport master (
    output req_valid, req_addr, inv_all, fill_ack, fill_done, tag_rddata,
    input  req_ready, rsp_valid, rsp_hit, fill_req, fill_addr, tag_addr, tag_wrdata, tag_wren
  );

  modport slave (
    input  req_valid, req_addr, inv_all, fill_ack, fill_done, tag_rddata,
    output req_ready, rsp_valid, rsp_hit, fill_req, fill_addr, tag_addr, tag_wrdata, tag_wren
  );
endinterface

// File: rtl/cache_tag_ctrl.sv
// Tag RAM port-A controller: sweeps the 2048-entry tag store clear, then serves hit/miss
// lookups and runs a line-fill handshake plus tag write on every miss.
module cache_tag_ctrl #(
  parameter int unsigned LINE_BITS = 5,
  parameter int unsigned ADDR_W    = 24
) (
  input logic             clk,
  input logic             rst_n,
  cache_tag_ctrl_if.slave bus
);

  // Line address = byte address without the offset bits; index is its low 11 bits, tag the next 8.
  localparam int unsigned LineW = ADDR_W - LINE_BITS;

  localparam logic [2:0] StClear = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StCmp   = 3'd3;
  localparam logic [2:0] StFill  = 3'd4;
  localparam logic [2:0] StWait  = 3'd5;
  localparam logic [2:0] StWrite = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [LineW-1:0]  line_q, line_d;
  logic              inv_pend_q, inv_pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;

  logic [10:0] index;
  logic [7:0]  tag;
  logic        hit;
  logic        inv_now;

  assign index   = line_q[10:0];
  assign tag     = line_q[18:11];
  assign hit     = bus.tag_rddata[8] & (bus.tag_rddata[7:0] == tag);
  assign inv_now = inv_pend_q | bus.inv_all;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    inv_pend_d  = inv_pend_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    fill_addr_d = fill_addr_q;

    // An invalidate that arrives while busy is remembered until the next return to IDLE.
    if (bus.inv_all && (state_q != StIdle)) begin
      inv_pend_d = 1'b1;
    end

    case (state_q)
      StClear: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == 11'h7ff) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (inv_now) begin
          state_d    = StClear;
          inv_pend_d = 1'b0;
        end else if (bus.req_valid) begin
          line_d  = bus.req_addr[ADDR_W-1:LINE_BITS];
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StCmp;
      end
      StCmp: begin
        if (hit) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          state_d     = StIdle;
        end else begin
          fill_addr_d = {line_q, {LINE_BITS{1'b0}}};
          state_d     = StFill;
        end
      end
      StFill: begin
        if (bus.fill_ack) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.fill_done) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StClear;
        cnt_d   = 11'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      cnt_q       <= 11'd0;
      line_q      <= '0;
      inv_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      inv_pend_q  <= inv_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  // Ready is withheld in an IDLE cycle that is about to start a clear, so no request is lost.
  always_comb begin
    bus.req_ready  = (state_q == StIdle) & ~inv_now;
    bus.rsp_valid  = rsp_valid_q;
    bus.rsp_hit    = rsp_hit_q;
    bus.fill_req   = (state_q == StFill);
    bus.fill_addr  = fill_addr_q;
    bus.tag_wren   = (state_q == StClear) | (state_q == StWrite);
    bus.tag_addr   = (state_q == StClear) ? cnt_q : index;
    bus.tag_wrdata = (state_q == StWrite) ? {1'b1, tag} : 9'h000;
  end

endmodule
